// File: rtl/sw_ctrl_conditioner.sv
// Switch front-end: 2-FF sync + debounce per raw input, mode/start FSM.
// Ports: clk, rst_n, raw MODE1/MODE2/BUZZER/START, DONE_I; MODE_O, START_PULSE_O,
//        RUN_O, CONFLICT_O, BUZZER_EN_O, LED1_ON_o, LED2_ON_o.
module sw_ctrl_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       MODE1_START_I,
    input  logic       MODE2_START_I,
    input  logic       BUZZER_MODE_I,
    input  logic       START_I,
    input  logic       DONE_I,
    output logic [1:0] MODE_O,
    output logic       START_PULSE_O,
    output logic       RUN_O,
    output logic       CONFLICT_O,
    output logic       BUZZER_EN_O,
    output logic       LED1_ON_o,
    output logic       LED2_ON_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // Channel order: 0 MODE1, 1 MODE2, 2 BUZZER, 3 START
    logic [3:0]            raw;
    logic [3:0]            sync1;
    logic [3:0]            sync2;
    logic [3:0]            stable;
    logic [3:0][CNT_W-1:0] cnt;
    logic                  start_d;

    assign raw = {START_I, BUZZER_MODE_I, MODE2_START_I, MODE1_START_I};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            cnt     <= '0;
            start_d <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            start_d <= stable[3];
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    logic m1;
    logic m2;
    logic start_rise;

    assign m1         = stable[0];
    assign m2         = stable[1];
    assign start_rise = stable[3] & ~start_d;

    state_t     state_q;
    state_t     state_n;
    logic [1:0] mode_q;
    logic [1:0] mode_n;
    logic       pulse_q;
    logic       pulse_n;
    logic       run_q;
    logic       run_n;
    logic       conf_q;
    logic       conf_n;
    logic       mode_ok;

    // The armed mode stays valid only while its switch alone is high
    assign mode_ok = mode_q[0] ? (m1 & ~m2) : (m2 & ~m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            pulse_q <= 1'b0;
            run_q   <= 1'b0;
            conf_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            mode_q  <= mode_n;
            pulse_q <= pulse_n;
            run_q   <= run_n;
            conf_q  <= conf_n;
        end
    end

    always_comb begin
        state_n = state_q;
        mode_n  = mode_q;
        pulse_n = 1'b0;
        run_n   = 1'b0;
        conf_n  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                mode_n = 2'b00;
                conf_n = m1 & m2;
                if (m1 & ~m2) begin
                    state_n = S_ARMED;
                    mode_n  = 2'b01;
                end else if (m2 & ~m1) begin
                    state_n = S_ARMED;
                    mode_n  = 2'b10;
                end
            end
            S_ARMED: begin
                // A mode drop beats a simultaneous start press
                if (!mode_ok) begin
                    state_n = S_IDLE;
                    mode_n  = 2'b00;
                end else if (start_rise) begin
                    state_n = S_RUN;
                    run_n   = 1'b1;
                    pulse_n = 1'b1;
                end
            end
            S_RUN: begin
                if (DONE_I) begin
                    state_n = S_IDLE;
                    mode_n  = 2'b00;
                end else begin
                    run_n = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                mode_n  = 2'b00;
            end
        endcase
    end

    assign MODE_O        = mode_q;
    assign START_PULSE_O = pulse_q;
    assign RUN_O         = run_q;
    assign CONFLICT_O    = conf_q;
    assign BUZZER_EN_O   = stable[2];
    assign LED1_ON_o     = mode_q[0];
    assign LED2_ON_o     = mode_q[1];

endmodule
